fsm_txrspcollector: RTL and testbench

//  Return path of the command channel. Collects read responses from up to MODULES_CNT modules.

---
 rtl/cmd_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/fsm_txrspcollector.sv | 125 ++++++++++++
 tb/tb_fsm_txrspcollector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command-channel definitions: header field offsets, FSM state type and header packing.
// The same offsets are used by the RX parser, so TX and RX agree on the header layout.
package cmd_pkg;

    localparam int RW_BIT       = 0;
    localparam int MODSEL_LSB   = 1;
    localparam int MODSEL_W     = 5;
    localparam int CMD_W        = 5;
    localparam int CMD_LSB      = MODSEL_LSB + MODSEL_W;
    localparam int HDR_W        = 32;
    localparam int SEQNUM_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // Packs a header word for the default field widths; seq occupies the top byte.
    function automatic logic [HDR_W-1:0] pack_hdr(
        input logic [MODSEL_W-1:0]     id,
        input logic [CMD_W-1:0]        cmd,
        input logic [SEQNUM_WIDTH-1:0] seq
    );
        logic [HDR_W-1:0] h;
        h                          = '0;
        h[RW_BIT]                  = 1'b1;
        h[MODSEL_LSB +: MODSEL_W]  = id;
        h[CMD_LSB +: CMD_W]        = cmd;
        h[HDR_W-1 -: SEQNUM_WIDTH] = seq;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request strictly after last_grant_i, wrapping.
// Zero latency; no backpressure of its own, the caller decides when a grant is taken.
module rr_arbiter #(
    parameter  int N  = 19,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found       = 1'b0;
        cand        = '0;
        grant_idx_o = '0;
        // Scan from last_grant+1 so the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_grant_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
        end
        any_o   = |req_i;
        grant_o = any_o ? (N'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/fsm_txrspcollector.sv
// Collects module responses round-robin and writes header+data words to the TX FIFOs (TXRSP_SEQNUM_EN adds a header seq byte).
// Ack-to-write latency 1 cycle; i_tx_full stalls in S_WRITE with outputs held and no further acks.
module fsm_txrspcollector
    import cmd_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH     = 32,
    parameter int FIFO_CMD_WIDTH      = 32,
    parameter int CMD_OUTPUT_WIDTH    = 5,
    parameter int MODULE_SELECT_WIDTH = 5,
    parameter int MODULES_CNT         = 19
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [MODULES_CNT-1:0]                           i_rsp_valid,
    input  logic [MODULES_CNT-1:0][CMD_OUTPUT_WIDTH-1:0]     i_rsp_cmd,
    input  logic [MODULES_CNT-1:0][FIFO_DATA_WIDTH-1:0]      i_rsp_data,
    output logic [MODULES_CNT-1:0]                           o_rsp_ack,
    output logic [FIFO_CMD_WIDTH-1:0]                        o_tx_hdr,
    output logic [FIFO_DATA_WIDTH-1:0]                       o_tx_data,
    output logic                                             o_tx_wr_en,
    input  logic                                             i_tx_full,
    output logic                                             o_busy,
    output logic [15:0]                                      o_rsp_count
);

    localparam int IDX_W   = (MODULES_CNT > 1) ? $clog2(MODULES_CNT) : 1;
    localparam int CMD_POS = MODSEL_LSB + MODULE_SELECT_WIDTH;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic [FIFO_CMD_WIDTH-1:0]  hdr_q, hdr_d, hdr_new;
    logic [FIFO_DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]                cnt_q, cnt_d;

    logic [MODULES_CNT-1:0]     grant;
    logic [IDX_W-1:0]           grant_idx;
    logic                       grant_any;

    rr_arbiter #(.N(MODULES_CNT)) u_arb (
        .req_i        (i_rsp_valid),
        .last_grant_i (rr_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_o        (grant_any)
    );

`ifdef TXRSP_SEQNUM_EN
    logic [SEQNUM_WIDTH-1:0] seq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (o_tx_wr_en) begin
            seq_q <= seq_q + 1'b1;
        end
    end
`endif

    // Module ID on the wire is index+1 so that ID 0 never appears.
    always_comb begin
        hdr_new                                       = '0;
        hdr_new[RW_BIT]                               = 1'b1;
        hdr_new[MODSEL_LSB +: MODULE_SELECT_WIDTH]    = MODULE_SELECT_WIDTH'(grant_idx) + 1'b1;
        hdr_new[CMD_POS +: CMD_OUTPUT_WIDTH]          = i_rsp_cmd[grant_idx];
`ifdef TXRSP_SEQNUM_EN
        hdr_new[FIFO_CMD_WIDTH-1 -: SEQNUM_WIDTH]     = seq_q;
`endif
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        o_rsp_ack  = '0;
        o_tx_wr_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    o_rsp_ack = grant;
                    rr_d      = grant_idx;
                    hdr_d     = hdr_new;
                    data_d    = i_rsp_data[grant_idx];
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!i_tx_full) begin
                    o_tx_wr_en = 1'b1;
                    cnt_d      = cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A response caught by reset is dropped: no ack and no write in the reset cycle.
        if (rst) begin
            o_rsp_ack  = '0;
            o_tx_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= IDX_W'(MODULES_CNT - 1);
            hdr_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_tx_hdr    = hdr_q;
    assign o_tx_data   = data_q;
    assign o_busy      = (state_q == S_WRITE);
    assign o_rsp_count = cnt_q;

endmodule

// File: tb/tb_fsm_txrspcollector.sv
// Directed bench for fsm_txrspcollector: inputs change at negedge, outputs sampled 1ns later.
module tb_fsm_txrspcollector;

    localparam int N = 19;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         i_rsp_valid;
    logic [N-1:0][4:0]    i_rsp_cmd;
    logic [N-1:0][31:0]   i_rsp_data;
    logic [N-1:0]         o_rsp_ack;
    logic [31:0]          o_tx_hdr;
    logic [31:0]          o_tx_data;
    logic                 o_tx_wr_en;
    logic                 i_tx_full;
    logic                 o_busy;
    logic [15:0]          o_rsp_count;

    int total = 0;
    int bad   = 0;
    int exp_seq = 0;
    logic [31:0] held_hdr, held_data;

    always #5 clk = ~clk;

    fsm_txrspcollector dut (
        .clk         (clk),
        .rst         (rst),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_cmd   (i_rsp_cmd),
        .i_rsp_data  (i_rsp_data),
        .o_rsp_ack   (o_rsp_ack),
        .o_tx_hdr    (o_tx_hdr),
        .o_tx_data   (o_tx_data),
        .o_tx_wr_en  (o_tx_wr_en),
        .i_tx_full   (i_tx_full),
        .o_busy      (o_busy),
        .o_rsp_count (o_rsp_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Header: bit0=1, ID in [5:1], cmd in [10:6], seq byte on top when enabled.
    function automatic logic [31:0] hdr_exp(input int id, input int cmd);
        logic [31:0] h;
        h = 32'd1 | (32'(id) << 1) | (32'(cmd) << 6);
`ifdef TXRSP_SEQNUM_EN
        h = h | (32'(exp_seq) << 24);
`endif
        return h;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        i_rsp_valid = '0;
        i_tx_full   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_seq = 0;
        #1;
    endtask

    task automatic chk_write(input string tag, input int id, input int cmd, input logic [31:0] d);
        chk({tag, "_wr"},   64'(o_tx_wr_en), 64'd1);
        chk({tag, "_hdr"},  64'(o_tx_hdr),   64'(hdr_exp(id, cmd)));
        chk({tag, "_data"}, 64'(o_tx_data),  64'(d));
        exp_seq = (exp_seq + 1) % 256;
    endtask

    initial begin
        rst         = 1'b1;
        i_rsp_valid = '0;
        i_rsp_cmd   = '0;
        i_rsp_data  = '0;
        i_tx_full   = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ack",   64'(o_rsp_ack),   64'd0);
        chk("rst_wr",    64'(o_tx_wr_en),  64'd0);
        do_reset();
        chk("rst_hdr",   64'(o_tx_hdr),    64'd0);
        chk("rst_data",  64'(o_tx_data),   64'd0);
        chk("rst_busy",  64'(o_busy),      64'd0);
        chk("rst_count", 64'(o_rsp_count), 64'd0);

        // 1: single response from module 0, header 0xC3.
        i_rsp_valid[0] = 1'b1;
        i_rsp_cmd[0]   = 5'h03;
        i_rsp_data[0]  = 32'hDEADBEEF;
        #1;
        chk("t1_ack", 64'(o_rsp_ack), 64'h1);
        next_cycle();
        i_rsp_valid = '0;
        #1;
        chk("t1_busy", 64'(o_busy), 64'd1);
        chk("t1_hdr_literal", 64'(o_tx_hdr), 64'h0000_00C3);
        chk_write("t1", 1, 3, 32'hDEADBEEF);
        next_cycle();
        chk("t1_count", 64'(o_rsp_count), 64'd1);
        chk("t1_idle",  64'(o_busy),      64'd0);

        // 2: modules 2 and 7 together, RR pointer at 0.
        i_rsp_cmd  = '0;
        i_rsp_data[2] = 32'h2222_0002;
        i_rsp_data[7] = 32'h7777_0007;
        i_rsp_valid[2] = 1'b1;
        i_rsp_valid[7] = 1'b1;
        #1;
        chk("t2_ack2", 64'(o_rsp_ack), 64'(1 << 2));
        next_cycle();
        chk("t2_noack", 64'(o_rsp_ack), 64'd0);
        chk_write("t2a", 3, 0, 32'h2222_0002);
        next_cycle();
        chk("t2_ack7", 64'(o_rsp_ack), 64'(1 << 7));
        next_cycle();
        i_rsp_valid = '0;
        #1;
        chk_write("t2b", 8, 0, 32'h7777_0007);
        next_cycle();

        // 3: all valid for 40 cycles from fresh reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            i_rsp_cmd[i]  = 5'(i + 1);
            i_rsp_data[i] = 32'hA000_0000 + 32'(i);
        end
        i_rsp_valid = '1;
        #1;
        for (int c = 0; c < 40; c++) begin
            int g;
            g = (c / 2) % N;
            if (c % 2 == 0) begin
                chk($sformatf("t3_ack_c%0d", c), 64'(o_rsp_ack), 64'(1 << g));
            end else begin
                chk($sformatf("t3_ack0_c%0d", c), 64'(o_rsp_ack), 64'd0);
                chk_write($sformatf("t3_c%0d", c), g + 1, g + 1, 32'hA000_0000 + 32'(g));
            end
            next_cycle();
        end
        i_rsp_valid = '0;
        #1;
        chk("t3_count", 64'(o_rsp_count), 64'd20);

        // 4: stall with full for 10 cycles; module 9 waits meanwhile.
        i_rsp_cmd[5]   = 5'h1F;
        i_rsp_data[5]  = 32'h5555_AAAA;
        i_rsp_valid[5] = 1'b1;
        i_tx_full      = 1'b1;
        #1;
        chk("t4_ack5", 64'(o_rsp_ack), 64'(1 << 5));
        next_cycle();
        i_rsp_valid    = '0;
        i_rsp_valid[9] = 1'b1;
        #1;
        held_hdr  = hdr_exp(6, 31);
        held_data = 32'h5555_AAAA;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t4_wr0_c%0d", c),  64'(o_tx_wr_en), 64'd0);
            chk($sformatf("t4_ack0_c%0d", c), 64'(o_rsp_ack),  64'd0);
            chk($sformatf("t4_hdr_c%0d", c),  64'(o_tx_hdr),   64'(held_hdr));
            chk($sformatf("t4_dat_c%0d", c),  64'(o_tx_data),  64'(held_data));
            if (c < 9) next_cycle();
        end
        next_cycle();
        i_tx_full = 1'b0;
        #1;
        chk_write("t4", 6, 31, 32'h5555_AAAA);
        next_cycle();
        chk("t4_ack9", 64'(o_rsp_ack), 64'(1 << 9));
        next_cycle();
        i_rsp_valid = '0;
        #1;
        chk_write("t4b", 10, 10, 32'hA000_0009);
        next_cycle();
        chk("t4_count", 64'(o_rsp_count), 64'd22);

        // 5: reset while holding a response in S_WRITE.
        i_rsp_valid[4] = 1'b1;
        #1;
        chk("t5_ack4", 64'(o_rsp_ack), 64'(1 << 4));
        next_cycle();
        i_rsp_valid = '0;
        rst         = 1'b1;
        #1;
        chk("t5_wr_in_rst", 64'(o_tx_wr_en), 64'd0);
        next_cycle();
        rst = 1'b0;
        exp_seq = 0;
        #1;
        chk("t5_busy",  64'(o_busy),      64'd0);
        chk("t5_hdr",   64'(o_tx_hdr),    64'd0);
        chk("t5_data",  64'(o_tx_data),   64'd0);
        chk("t5_count", 64'(o_rsp_count), 64'd0);
        chk("t5_wr",    64'(o_tx_wr_en),  64'd0);
        i_rsp_valid[0] = 1'b1;
        i_rsp_valid[5] = 1'b1;
        #1;
        chk("t5_rr0", 64'(o_rsp_ack), 64'h1);
        next_cycle();
        i_rsp_valid = '0;
        #1;
        chk_write("t5", 1, 1, 32'hA000_0000);
        next_cycle();

        // 6: 257 writes from module 1; seq byte wraps when enabled, else stays 0.
        do_reset();
        i_rsp_valid[1] = 1'b1;
        #1;
        for (int k = 0; k < 257; k++) begin
            next_cycle();
`ifdef TXRSP_SEQNUM_EN
            chk($sformatf("t6_seq_%0d", k), 64'(o_tx_hdr[31:24]), 64'(k % 256));
`else
            chk($sformatf("t6_seq_%0d", k), 64'(o_tx_hdr[31:24]), 64'd0);
`endif
            chk($sformatf("t6_wr_%0d", k), 64'(o_tx_wr_en), 64'd1);
            next_cycle();
        end
        i_rsp_valid = '0;
        #1;
        chk("t6_count", 64'(o_rsp_count), 64'd257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
